id_stage_pipe: RTL and testbench

Parametrised instruction-decode stage with an integrated ID/EX pipeline register, load-use interlock, flush, downstream back-pressure, write-back bypass and a stall counter. Sits between the IF/ID register and EX in the MIPS pipeline. The existing `Control` decoder is instantiated unchanged inside it. The decode fields are now registered rather than passed through combinationally, so EX sees one clean, valid-qualified bundle per cycle.

---
 rtl/id_stage_pipe_if.sv | 59 +++++
 rtl/id_stage_pipe.sv | 181 ++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_pipe_if.sv
// Bus bundle for the ID stage: IF/ID handshake, register-file read port,
// write-back port, flush/back-pressure, and the registered ID/EX bundle.
interface id_stage_pipe_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic              id_ready;
    logic [31:0]       id_instruction;
    logic [PC_W-1:0]   id_pc_next;
    logic [4:0]        reg_addr1;
    logic [4:0]        reg_addr2;
    logic [DATA_W-1:0] reg_data1;
    logic [DATA_W-1:0] reg_data2;
    logic              wb_reg_write;
    logic [4:0]        wb_reg_addr;
    logic [DATA_W-1:0] wb_reg_data;
    logic              flush;
    logic              ex_ready;
    logic              ex_valid;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [4:0]        rd_addr;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] ext_imm;
    logic [5:0]        funct;
    logic [3:0]        alu_op;
    logic              alu_src;
    logic              reg_dst;
    logic              mem_write;
    logic              mem_read;
    logic              mem2reg;
    logic              reg_write;
    logic [1:0]        jump;
    logic [1:0]        branch;
    logic [PC_W-1:0]   pc_next;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_instruction, id_pc_next, reg_data1, reg_data2,
               wb_reg_write, wb_reg_addr, wb_reg_data, flush, ex_ready,
        input  id_ready, reg_addr1, reg_addr2, ex_valid, rs_data, rt_data,
               rs_addr, rt_addr, rd_addr, shamt, ext_imm, funct, alu_op,
               alu_src, reg_dst, mem_write, mem_read, mem2reg, reg_write,
               jump, branch, pc_next, stall_count
    );

    modport slave (
        input  id_valid, id_instruction, id_pc_next, reg_data1, reg_data2,
               wb_reg_write, wb_reg_addr, wb_reg_data, flush, ex_ready,
        output id_ready, reg_addr1, reg_addr2, ex_valid, rs_data, rt_data,
               rs_addr, rt_addr, rd_addr, shamt, ext_imm, funct, alu_op,
               alu_src, reg_dst, mem_write, mem_read, mem2reg, reg_write,
               jump, branch, pc_next, stall_count
    );
endinterface

// File: rtl/id_stage_pipe.sv
// MIPS instruction-decode stage with registered ID/EX bundle, load-use
// interlock, flush, EX back-pressure, write-back bypass and stall counter.

// Main opcode decoder. ALUOp: 0000 add, 0001 sub, 0010 R-type (use funct),
// 0011 or, 0100 and, 0101 xor, 0110 slt, 0111 lui.
module control (
    input  logic [5:0] op,
    output logic [3:0] alu_op,
    output logic       alu_src,
    output logic       reg_dst,
    output logic       mem_write,
    output logic       mem_read,
    output logic       mem2reg,
    output logic       reg_write,
    output logic [1:0] jump,
    output logic [1:0] branch
);
    // Opcode to control-signal table.
    always_comb begin
        alu_op    = 4'b0000;
        alu_src   = 1'b0;
        reg_dst   = 1'b0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        mem2reg   = 1'b0;
        reg_write = 1'b0;
        jump      = 2'b00;
        branch    = 2'b00;
        case (op)
            6'b000000: begin alu_op = 4'b0010; reg_dst = 1'b1; reg_write = 1'b1; end
            6'b001000,
            6'b001001: begin alu_src = 1'b1; reg_write = 1'b1; end
            6'b001100: begin alu_op = 4'b0100; alu_src = 1'b1; reg_write = 1'b1; end
            6'b001101: begin alu_op = 4'b0011; alu_src = 1'b1; reg_write = 1'b1; end
            6'b001110: begin alu_op = 4'b0101; alu_src = 1'b1; reg_write = 1'b1; end
            6'b001010: begin alu_op = 4'b0110; alu_src = 1'b1; reg_write = 1'b1; end
            6'b001111: begin alu_op = 4'b0111; alu_src = 1'b1; reg_write = 1'b1; end
            6'b100011: begin alu_src = 1'b1; mem_read = 1'b1; mem2reg = 1'b1; reg_write = 1'b1; end
            6'b101011: begin alu_src = 1'b1; mem_write = 1'b1; end
            6'b000100: begin alu_op = 4'b0001; branch = 2'b01; end
            6'b000101: begin alu_op = 4'b0001; branch = 2'b10; end
            6'b000010: jump = 2'b01;
            6'b000011: begin jump = 2'b10; reg_write = 1'b1; end
            default: ;
        endcase
    end
endmodule

module id_stage_pipe #(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input logic          clk,
    input logic          rst,
    id_stage_pipe_if.slave bus
);
    logic [5:0]        op, funct, ctrl_op;
    logic [4:0]        rs, rt, rd, shamt;
    logic [15:0]       imm;
    logic              is_jr, zero_ext, uses_rt, load_use, adv;
    logic              wb_hit1, wb_hit2;
    logic [DATA_W-1:0] ext_imm_d, rs_data_d, rt_data_d;
    logic [3:0]        c_alu_op;
    logic              c_alu_src, c_reg_dst, c_mem_write, c_mem_read, c_mem2reg, c_reg_write;
    logic [1:0]        c_jump, c_branch;
    logic [PC_W-1:0]   pc_next_q;
    logic [CNT_W-1:0]  stall_q;

    assign op    = bus.id_instruction[31:26];
    assign rs    = bus.id_instruction[25:21];
    assign rt    = bus.id_instruction[20:16];
    assign rd    = bus.id_instruction[15:11];
    assign shamt = bus.id_instruction[10:6];
    assign funct = bus.id_instruction[5:0];
    assign imm   = bus.id_instruction[15:0];

    assign bus.reg_addr1 = rs;
    assign bus.reg_addr2 = rt;

    // JR is decoded as a J by the opcode table, then its jump kind is overridden.
    assign is_jr   = (op == 6'b000000) && (funct == 6'b001000);
    assign ctrl_op = is_jr ? 6'b000010 : op;

    control u_control (
        .op        (ctrl_op),
        .alu_op    (c_alu_op),
        .alu_src   (c_alu_src),
        .reg_dst   (c_reg_dst),
        .mem_write (c_mem_write),
        .mem_read  (c_mem_read),
        .mem2reg   (c_mem2reg),
        .reg_write (c_reg_write),
        .jump      (c_jump),
        .branch    (c_branch)
    );

    assign zero_ext  = (op == 6'b001100) || (op == 6'b001101) || (op == 6'b001110);
    assign ext_imm_d = zero_ext ? {{(DATA_W-16){1'b0}}, imm} : {{(DATA_W-16){imm[15]}}, imm};

    // Register $0 is never a bypass source even if WB claims to write it.
    assign wb_hit1   = (WB_BYPASS != 0) && bus.wb_reg_write && (bus.wb_reg_addr != 5'd0)
                       && (bus.wb_reg_addr == rs);
    assign wb_hit2   = (WB_BYPASS != 0) && bus.wb_reg_write && (bus.wb_reg_addr != 5'd0)
                       && (bus.wb_reg_addr == rt);
    assign rs_data_d = wb_hit1 ? bus.wb_reg_data : bus.reg_data1;
    assign rt_data_d = wb_hit2 ? bus.wb_reg_data : bus.reg_data2;

    // rt is a source for R-type, beq, bne and sw; for the rest it is a destination.
    assign uses_rt  = (op == 6'b000000) || (op == 6'b000100) || (op == 6'b000101)
                      || (op == 6'b101011);
    assign load_use = bus.ex_valid && bus.mem_read && (bus.rt_addr != 5'd0)
                      && ((bus.rt_addr == rs) || ((bus.rt_addr == rt) && uses_rt));
    assign adv          = bus.ex_ready || !bus.ex_valid;
    assign bus.id_ready = adv && !load_use && !bus.flush;

    assign bus.pc_next     = pc_next_q;
    assign bus.stall_count = stall_q;

    // ID/EX register: flush beats hold, hold beats bubble/load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ex_valid  <= 1'b0;
            bus.rs_data   <= '0;
            bus.rt_data   <= '0;
            bus.rs_addr   <= '0;
            bus.rt_addr   <= '0;
            bus.rd_addr   <= '0;
            bus.shamt     <= '0;
            bus.ext_imm   <= '0;
            bus.funct     <= '0;
            bus.alu_op    <= '0;
            bus.alu_src   <= 1'b0;
            bus.reg_dst   <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_read  <= 1'b0;
            bus.mem2reg   <= 1'b0;
            bus.reg_write <= 1'b0;
            bus.jump      <= '0;
            bus.branch    <= '0;
            pc_next_q     <= '0;
        end else if (bus.flush || (adv && (load_use || !bus.id_valid))) begin
            bus.ex_valid  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_read  <= 1'b0;
            bus.reg_write <= 1'b0;
            bus.jump      <= '0;
            bus.branch    <= '0;
        end else if (adv) begin
            bus.ex_valid  <= 1'b1;
            bus.rs_data   <= rs_data_d;
            bus.rt_data   <= rt_data_d;
            bus.rs_addr   <= rs;
            bus.rt_addr   <= rt;
            bus.rd_addr   <= rd;
            bus.shamt     <= shamt;
            bus.ext_imm   <= ext_imm_d;
            bus.funct     <= funct;
            bus.alu_op    <= c_alu_op;
            bus.alu_src   <= c_alu_src;
            bus.reg_dst   <= c_reg_dst;
            bus.mem_write <= c_mem_write;
            bus.mem_read  <= c_mem_read;
            bus.mem2reg   <= c_mem2reg;
            bus.reg_write <= c_reg_write;
            bus.jump      <= is_jr ? 2'b11 : c_jump;
            bus.branch    <= c_branch;
            pc_next_q     <= bus.id_pc_next;
        end
    end

    // Saturating count of bubbles inserted by the load-use interlock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (load_use && adv && !bus.flush && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a vector table for the single-cycle
// behaviour plus hand sequences for bypass/JR and mid-stall async reset.
// A second instance (no bypass, 2-bit counter) shares the same stimulus.
module tb_id_stage_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    id_stage_pipe_if #(.DATA_W(32), .PC_W(32), .CNT_W(16)) bus  ();
    id_stage_pipe_if #(.DATA_W(32), .PC_W(32), .CNT_W(2))  bus2 ();

    id_stage_pipe #(.DATA_W(32), .PC_W(32), .WB_BYPASS(1), .CNT_W(16)) dut (
        .clk (clk), .rst (rst), .bus (bus.slave));
    id_stage_pipe #(.DATA_W(32), .PC_W(32), .WB_BYPASS(0), .CNT_W(2)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2.slave));

    assign bus2.id_valid       = bus.id_valid;
    assign bus2.id_instruction = bus.id_instruction;
    assign bus2.id_pc_next     = bus.id_pc_next;
    assign bus2.reg_data1      = bus.reg_data1;
    assign bus2.reg_data2      = bus.reg_data2;
    assign bus2.wb_reg_write   = bus.wb_reg_write;
    assign bus2.wb_reg_addr    = bus.wb_reg_addr;
    assign bus2.wb_reg_data    = bus.wb_reg_data;
    assign bus2.flush          = bus.flush;
    assign bus2.ex_ready       = bus.ex_ready;

    typedef struct {
        logic [31:0] instr;
        logic        valid, ex_rdy, flush;
        logic [31:0] rd1;
        logic        exp_ready, exp_valid, exp_rw, exp_mr, chk;
        logic [31:0] exp_imm, exp_rs;
        logic [1:0]  exp_br;
        int          exp_stall;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [31:0] instr, logic valid, logic ex_rdy, logic flush,
                                logic [31:0] rd1, logic exp_ready, logic exp_valid,
                                logic exp_rw, logic exp_mr, logic chk, logic [31:0] exp_imm,
                                logic [31:0] exp_rs, logic [1:0] exp_br, int exp_stall);
        vec_t v;
        v.instr = instr; v.valid = valid; v.ex_rdy = ex_rdy; v.flush = flush; v.rd1 = rd1;
        v.exp_ready = exp_ready; v.exp_valid = exp_valid; v.exp_rw = exp_rw; v.exp_mr = exp_mr;
        v.chk = chk; v.exp_imm = exp_imm; v.exp_rs = exp_rs; v.exp_br = exp_br;
        v.exp_stall = exp_stall;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic valid, input logic ex_rdy,
                         input logic flush, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic wbw, input logic [4:0] wba, input logic [31:0] wbd);
        bus.id_instruction = instr;
        bus.id_valid       = valid;
        bus.ex_ready       = ex_rdy;
        bus.flush          = flush;
        bus.reg_data1      = rd1;
        bus.reg_data2      = rd2;
        bus.wb_reg_write   = wbw;
        bus.wb_reg_addr    = wba;
        bus.wb_reg_data    = wbd;
        bus.id_pc_next     = 32'h0000_4000 + {16'h0, instr[15:0]};
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_vec(input int i, input vec_t v);
        int st2;
        st2 = (v.exp_stall > 3) ? 3 : v.exp_stall;
        drive(v.instr, v.valid, v.ex_rdy, v.flush, v.rd1, 32'h0000_0b0b, 1'b0, 5'd0, 32'h0);
        #1;
        check($sformatf("v%0d_ready", i), bus.id_ready, v.exp_ready);
        cycle();
        check($sformatf("v%0d_valid", i), bus.ex_valid, v.exp_valid);
        check($sformatf("v%0d_regwrite", i), bus.reg_write, v.exp_rw);
        check($sformatf("v%0d_memread", i), bus.mem_read, v.exp_mr);
        check($sformatf("v%0d_branch", i), bus.branch, v.exp_br);
        check($sformatf("v%0d_stall", i), bus.stall_count, v.exp_stall);
        check($sformatf("v%0d_stall_sat", i), bus2.stall_count, st2);
        check($sformatf("v%0d_valid2", i), bus2.ex_valid, v.exp_valid);
        if (v.chk) begin
            check($sformatf("v%0d_extimm", i), bus.ext_imm, v.exp_imm);
            check($sformatf("v%0d_rsdata", i), bus.rs_data, v.exp_rs);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          instr         v  er fl rd1           rdy val rw mr chk imm           rs            br     st
        vecs.push_back(mk(32'h2001_0005, 1, 1, 0, 32'h0,        1, 1, 1, 0, 1, 32'h0000_0005, 32'h0,        2'b00, 0));
        vecs.push_back(mk(32'h0021_1020, 1, 1, 0, 32'h5,        1, 1, 1, 0, 1, 32'h0000_1020, 32'h5,        2'b00, 0));
        vecs.push_back(mk(32'h8C23_0000, 1, 1, 0, 32'h5,        1, 1, 1, 1, 1, 32'h0,         32'h5,        2'b00, 0));
        vecs.push_back(mk(32'h0060_2020, 1, 1, 0, 32'h33,       0, 0, 0, 0, 0, 32'h0,         32'h0,        2'b00, 1));
        vecs.push_back(mk(32'h0060_2020, 1, 1, 0, 32'h33,       1, 1, 1, 0, 1, 32'h0000_2020, 32'h33,       2'b00, 1));
        vecs.push_back(mk(32'h3405_FFFF, 1, 1, 0, 32'h0,        1, 1, 1, 0, 1, 32'h0000_FFFF, 32'h0,        2'b00, 1));
        vecs.push_back(mk(32'h2005_FFFF, 1, 1, 0, 32'h0,        1, 1, 1, 0, 1, 32'hFFFF_FFFF, 32'h0,        2'b00, 1));
        vecs.push_back(mk(32'h2001_0005, 0, 1, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0,         32'h0,        2'b00, 1));
        vecs.push_back(mk(32'h8C46_0004, 1, 1, 0, 32'h10,       1, 1, 1, 1, 1, 32'h4,         32'h10,       2'b00, 1));
        vecs.push_back(mk(32'h2006_0001, 1, 1, 0, 32'h0,        1, 1, 1, 0, 1, 32'h1,         32'h0,        2'b00, 1));
        vecs.push_back(mk(32'h8C46_0004, 1, 1, 0, 32'h10,       1, 1, 1, 1, 1, 32'h4,         32'h10,       2'b00, 1));
        vecs.push_back(mk(32'hAC06_0000, 1, 1, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,         32'h0,        2'b00, 2));
        vecs.push_back(mk(32'hAC06_0000, 1, 1, 0, 32'h0,        1, 1, 0, 0, 1, 32'h0,         32'h0,        2'b00, 2));
        vecs.push_back(mk(32'h8C20_0000, 1, 1, 0, 32'h20,       1, 1, 1, 1, 1, 32'h0,         32'h20,       2'b00, 2));
        vecs.push_back(mk(32'h0000_2020, 1, 1, 0, 32'h0,        1, 1, 1, 0, 1, 32'h0000_2020, 32'h0,        2'b00, 2));
        vecs.push_back(mk(32'h8C29_0008, 1, 1, 0, 32'h7,        1, 1, 1, 1, 1, 32'h8,         32'h7,        2'b00, 2));
        vecs.push_back(mk(32'h1009_0001, 1, 1, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,         32'h0,        2'b00, 3));
        vecs.push_back(mk(32'h1009_0001, 1, 1, 0, 32'h0,        1, 1, 0, 0, 1, 32'h1,         32'h0,        2'b01, 3));
        vecs.push_back(mk(32'h8C29_0008, 1, 1, 0, 32'h7,        1, 1, 1, 1, 1, 32'h8,         32'h7,        2'b00, 3));
        vecs.push_back(mk(32'h1520_0001, 1, 1, 0, 32'h99,       0, 0, 0, 0, 0, 32'h0,         32'h0,        2'b00, 4));
        vecs.push_back(mk(32'h1520_0001, 1, 1, 0, 32'h99,       1, 1, 0, 0, 1, 32'h1,         32'h99,       2'b10, 4));
        vecs.push_back(mk(32'h2001_0005, 1, 0, 0, 32'h0,        0, 1, 0, 0, 1, 32'h1,         32'h99,       2'b10, 4));
        vecs.push_back(mk(32'h2001_0005, 1, 0, 0, 32'h0,        0, 1, 0, 0, 1, 32'h1,         32'h99,       2'b10, 4));
        vecs.push_back(mk(32'h2001_0005, 1, 0, 1, 32'h0,        0, 0, 0, 0, 0, 32'h0,         32'h0,        2'b00, 4));
        vecs.push_back(mk(32'h0000_0000, 0, 1, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0,         32'h0,        2'b00, 4));
        vecs.push_back(mk(32'h8C23_0000, 1, 1, 0, 32'h5,        1, 1, 1, 1, 1, 32'h0,         32'h5,        2'b00, 4));
        vecs.push_back(mk(32'h0060_2020, 1, 0, 0, 32'h33,       0, 1, 1, 1, 1, 32'h0,         32'h5,        2'b00, 4));
        vecs.push_back(mk(32'h0060_2020, 1, 1, 0, 32'h33,       0, 0, 0, 0, 0, 32'h0,         32'h0,        2'b00, 5));
        vecs.push_back(mk(32'h0060_2020, 1, 1, 0, 32'h33,       1, 1, 1, 0, 1, 32'h0000_2020, 32'h33,       2'b00, 5));
        vecs.push_back(mk(32'h8C23_0000, 1, 1, 0, 32'h5,        1, 1, 1, 1, 1, 32'h0,         32'h5,        2'b00, 5));
        vecs.push_back(mk(32'h0060_2020, 1, 1, 1, 32'h33,       0, 0, 0, 0, 0, 32'h0,         32'h0,        2'b00, 5));
        vecs.push_back(mk(32'h0060_2020, 1, 1, 0, 32'h33,       1, 1, 1, 0, 1, 32'h0000_2020, 32'h33,       2'b00, 5));

        drive(32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", bus.ex_valid, 0);
        check("rst_stall", bus.stall_count, 0);
        check("rst_regwrite", bus.reg_write, 0);
        check("rst_memread", bus.mem_read, 0);
        check("rst_jump", bus.jump, 0);
        check("rst_extimm", bus.ext_imm, 0);
        check("rst_pcnext", bus.pc_next, 0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply_vec(i, vecs[i]);

        // jr $7 while WB writes $7: bypassed on dut, raw register file on dut2.
        drive(32'h00E0_0008, 1'b1, 1'b1, 1'b0, 32'h1111_1111, 32'h0, 1'b1, 5'd7, 32'hDEAD_BEEF);
        #1 check("jr_ready", bus.id_ready, 1);
        cycle();
        check("jr_valid", bus.ex_valid, 1);
        check("jr_rsdata_bypass", bus.rs_data, 32'hDEAD_BEEF);
        check("jr_jump", bus.jump, 2'b11);
        check("jr_regwrite", bus.reg_write, 0);
        check("jr_pcnext", bus.pc_next, 32'h0000_4008);
        check("jr_rsdata_nobypass", bus2.rs_data, 32'h1111_1111);
        check("jr_jump_nobypass", bus2.jump, 2'b11);

        drive(32'h00E0_0008, 1'b1, 1'b1, 1'b0, 32'h1111_1111, 32'h0, 1'b0, 5'd7, 32'hDEAD_BEEF);
        cycle();
        check("jr_nowrite_rsdata", bus.rs_data, 32'h1111_1111);

        drive(32'h0000_2020, 1'b1, 1'b1, 1'b0, 32'h5, 32'h6, 1'b1, 5'd0, 32'hAAAA_AAAA);
        cycle();
        check("wb_r0_rsdata", bus.rs_data, 32'h5);
        check("wb_r0_rtdata", bus.rt_data, 32'h6);

        drive(32'h0027_1020, 1'b1, 1'b1, 1'b0, 32'h1, 32'h22, 1'b1, 5'd7, 32'hCAFE_F00D);
        cycle();
        check("wb_rt_bypass", bus.rt_data, 32'hCAFE_F00D);
        check("wb_rt_nobypass", bus2.rt_data, 32'h22);
        check("wb_rt_rsdata", bus.rs_data, 32'h1);

        // Async reset pulsed in the middle of a load-use stall cycle.
        drive(32'h8C23_0000, 1'b1, 1'b1, 1'b0, 32'h5, 32'h0, 1'b0, 5'd0, 32'h0);
        cycle();
        drive(32'h0060_2020, 1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 5'd0, 32'h0);
        #1 check("ar_stall_ready", bus.id_ready, 0);
        #1 rst = 1'b1;
        #1;
        check("ar_valid", bus.ex_valid, 0);
        check("ar_memread", bus.mem_read, 0);
        check("ar_regwrite", bus.reg_write, 0);
        check("ar_rsdata", bus.rs_data, 0);
        check("ar_stall", bus.stall_count, 0);
        check("ar_stall2", bus2.stall_count, 0);
        check("ar_ready", bus.id_ready, 1);
        #1 rst = 1'b0;
        cycle();
        check("ar_next_valid", bus.ex_valid, 1);
        check("ar_next_rsdata", bus.rs_data, 32'h44);
        check("ar_next_regwrite", bus.reg_write, 1);
        check("ar_next_stall", bus.stall_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
